bypass_tracker: RTL
===================

Name: bypass_tracker

Overview:
- Producer side of the operand-forwarding interface.
- Tracks every in-flight register write through the EX, MEM_REQ, MEM_RESP and WB stages.
- Drives the per-stage rd, write-enable and ALU-result buses that the operand-forwarding selectors consume.
- Raises a load-use interlock when a needed value is a load result not yet in WB, and inserts bubbles accordingly.

Parameters:
- XLEN, 32, data width of ALU results.
- NREG_BITS, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_in  in  1  global pipeline freeze (e.g. memory wait); holds all stages.
- flush  in  1  kill the instruction entering EX this cycle (branch redirect).
- issue_valid  in  1  a decoded instruction is presented for entry into EX.
- issue_rd  in  NREG_BITS  destination of the issuing instruction.
- issue_we  in  1  issuing instruction writes rd.
- issue_is_load  in  1  issuing instruction is a load.
- issue_rs1, issue_rs2  in  NREG_BITS  source registers of the issuing instruction.
- issue_uses_rs1, issue_uses_rs2  in  1  source is actually read.
- ex_result  in  XLEN  ALU result of the instruction currently in EX.
- ex_rd, mem_req_rd, mem_resp_rd, wb_rd  out  NREG_BITS  per-stage destination.
- ex_reg_we, mem_req_reg_we, mem_resp_reg_we, wb_reg_we  out  1  per-stage forwardable write-enable.
- mem_req_alu_result, mem_resp_alu_result  out  XLEN  registered ALU results.
- load_use_stall  out  1  hold decode/issue; a bubble enters EX.

Behaviour:
- Stage state: each of EX, MEM_REQ, MEM_RESP and WB holds {rd, we, is_load}. MEM_REQ and MEM_RESP additionally hold an XLEN result.
- Reset (asynchronous): all rd, we, is_load and result registers go to 0; all outputs read 0.
- Write-enable qualification at capture: stored we = issue_valid & issue_we & (issue_rd != 0). Register x0 is never tracked as written.
- Load-use hazard: for each used source rs with rs != 0, a hazard exists if any of EX, MEM_REQ or MEM_RESP holds we=1, is_load=1 and rd=rs.
  - load_use_stall is combinational from the current stage state and issue inputs, qualified by issue_valid.
  - It is independent of stall_in.
- Advance (stall_in=0), at the clock edge:
  - WB takes MEM_RESP; MEM_RESP takes MEM_REQ (including result); MEM_REQ takes EX with result = ex_result.
  - EX takes the issue fields if issue_valid=1, load_use_stall=0 and flush=0; otherwise EX takes a bubble (we=0, is_load=0, rd=0).
- Freeze (stall_in=1): all stages hold, including EX.
  - Exception: if flush=1, EX becomes a bubble; flush beats stall_in for EX only.
- Output masking:
  - ex_reg_we = EX.we & ~EX.is_load; mem_req_reg_we and mem_resp_reg_we are masked the same way.
  - wb_reg_we = WB.we; loads are forwardable only from WB.
  - rd outputs are raw stage rd values.
- Latency:
  - An ALU producer is forwardable from EX on the cycle after issue, so a dependent instruction has zero stall.
  - A load producer costs up to 3 stall cycles for a back-to-back dependent instruction (EX, MEM_REQ, MEM_RESP).
- Simultaneous events:
  - flush together with load_use_stall: a bubble enters EX and load_use_stall remains asserted combinationally. Upstream ignores it because of the flush.
  - rst asserted mid-stall clears everything immediately; load_use_stall drops in the same cycle.
- Results are not reset-sensitive beyond the initial clear. The result register of a bubble holds whatever ex_result was sampled; it is don't-care because we=0.

Decomposition:
- Shared pipeline package holds:
  - stage_t struct {rd, we, is_load};
  - BUBBLE constant (all-zero stage_t);
  - XLEN and NREG_BITS constants.
- One natural sub-module: bypass_stage_reg. It is a single stage register with async reset, hold and bubble-insert controls, and is instantiated four times.
- Hazard comparison stays in the top level.

Test Plan:
- Reset: assert rst mid-stream with stages populated -> all outputs 0 within the same cycle, load_use_stall=0.
- ALU chain: issue rd=5 (ALU) then rs1=5 next cycle with ex_result=0x1234 -> no stall; next cycle mem_req_rd=5, mem_req_reg_we=1, mem_req_alu_result=0x1234; WB reaches rd=5 three advances later.
- Load-use: issue load rd=7, then an instruction using rs2=7 -> load_use_stall high for exactly 3 cycles; 3 bubbles enter EX; ex/mem_req/mem_resp_reg_we stay 0 for rd=7; wb_rd=7 with wb_reg_we=1 when the stall drops.
- x0 writes: issue rd=0 with issue_we=1 -> all stage we stay 0. A later load to rd=0 followed by a use of rs1=0 -> no stall.
- Freeze/flush: hold stall_in=1 for 2 cycles with all stages valid -> state unchanged. With flush=1 during the freeze -> only EX becomes a bubble; after release the older stages shift normally.
- Unused-source: a load to rd=3 followed by an instruction with rs1=3 but issue_uses_rs1=0 -> load_use_stall=0.

Source files
------------

// File: rtl/bypass_tracker_pkg.sv
// Shared pipeline definitions for the operand-forwarding producer side.
// stage_t is the per-stage bookkeeping every tracked pipeline stage carries.
package bypass_tracker_pkg;

   localparam int XLEN      = 32;
   localparam int NREG_BITS = 5;

   typedef struct packed {
      logic [NREG_BITS-1:0] rd;
      logic                 we;
      logic                 is_load;
   } stage_t;

   localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/bypass_tracker_stage_reg.sv
// One tracked pipeline stage: async clear, hold on freeze, bubble insertion.
// Bubble insertion wins over hold so a flush can kill a frozen stage.
module bypass_stage_reg
   import bypass_tracker_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   hold,
   input  logic   insert_bubble,
   input  stage_t d,
   output stage_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= BUBBLE;
      end else if (insert_bubble) begin
         q <= BUBBLE;
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/bypass_tracker.sv
// Tracks in-flight register writes through EX, MEM_REQ, MEM_RESP and WB,
// publishes forwardable write info per stage and raises the load-use interlock.
module bypass_tracker #(
   parameter int XLEN      = bypass_tracker_pkg::XLEN,
   parameter int NREG_BITS = bypass_tracker_pkg::NREG_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_in,
   input  logic                 flush,
   input  logic                 issue_valid,
   input  logic [NREG_BITS-1:0] issue_rd,
   input  logic                 issue_we,
   input  logic                 issue_is_load,
   input  logic [NREG_BITS-1:0] issue_rs1,
   input  logic [NREG_BITS-1:0] issue_rs2,
   input  logic                 issue_uses_rs1,
   input  logic                 issue_uses_rs2,
   input  logic [XLEN-1:0]      ex_result,
   output logic [NREG_BITS-1:0] ex_rd,
   output logic [NREG_BITS-1:0] mem_req_rd,
   output logic [NREG_BITS-1:0] mem_resp_rd,
   output logic [NREG_BITS-1:0] wb_rd,
   output logic                 ex_reg_we,
   output logic                 mem_req_reg_we,
   output logic                 mem_resp_reg_we,
   output logic                 wb_reg_we,
   output logic [XLEN-1:0]      mem_req_alu_result,
   output logic [XLEN-1:0]      mem_resp_alu_result,
   output logic                 load_use_stall
);

   import bypass_tracker_pkg::*;

   stage_t          issue_stage;
   stage_t          ex_q;
   stage_t          mem_req_q;
   stage_t          mem_resp_q;
   stage_t          wb_q;
   logic            ex_insert_bubble;
   logic            rs1_hazard;
   logic            rs2_hazard;
   logic [XLEN-1:0] mem_req_result;
   logic [XLEN-1:0] mem_resp_result;

   function automatic logic load_hit(input stage_t s, input logic [NREG_BITS-1:0] rs);
      return s.we && s.is_load && (s.rd == rs);
   endfunction

   // x0 is never tracked as written, so its write-enable is dropped at capture.
   always_comb begin
      issue_stage         = BUBBLE;
      issue_stage.rd      = issue_rd;
      issue_stage.we      = issue_valid && issue_we && (issue_rd != '0);
      issue_stage.is_load = issue_is_load;
   end

   // A load still short of WB cannot be forwarded yet; hold the consumer.
   always_comb begin
      rs1_hazard = issue_uses_rs1 && (issue_rs1 != '0) &&
                   (load_hit(ex_q, issue_rs1) || load_hit(mem_req_q, issue_rs1) ||
                    load_hit(mem_resp_q, issue_rs1));
      rs2_hazard = issue_uses_rs2 && (issue_rs2 != '0) &&
                   (load_hit(ex_q, issue_rs2) || load_hit(mem_req_q, issue_rs2) ||
                    load_hit(mem_resp_q, issue_rs2));
      load_use_stall = issue_valid && (rs1_hazard || rs2_hazard);
   end

   assign ex_insert_bubble = flush || (!stall_in && (!issue_valid || load_use_stall));

   bypass_stage_reg u_ex (
      .clk           (clk),
      .rst           (rst),
      .hold          (stall_in),
      .insert_bubble (ex_insert_bubble),
      .d             (issue_stage),
      .q             (ex_q)
   );

   bypass_stage_reg u_mem_req (
      .clk           (clk),
      .rst           (rst),
      .hold          (stall_in),
      .insert_bubble (1'b0),
      .d             (ex_q),
      .q             (mem_req_q)
   );

   bypass_stage_reg u_mem_resp (
      .clk           (clk),
      .rst           (rst),
      .hold          (stall_in),
      .insert_bubble (1'b0),
      .d             (mem_req_q),
      .q             (mem_resp_q)
   );

   bypass_stage_reg u_wb (
      .clk           (clk),
      .rst           (rst),
      .hold          (stall_in),
      .insert_bubble (1'b0),
      .d             (mem_resp_q),
      .q             (wb_q)
   );

   // Results travel alongside MEM_REQ/MEM_RESP; bubble results are don't-care.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req_result  <= '0;
         mem_resp_result <= '0;
      end else if (!stall_in) begin
         mem_req_result  <= ex_result;
         mem_resp_result <= mem_req_result;
      end
   end

   // Load data only becomes forwardable once it reaches WB.
   assign ex_rd               = ex_q.rd;
   assign mem_req_rd          = mem_req_q.rd;
   assign mem_resp_rd         = mem_resp_q.rd;
   assign wb_rd               = wb_q.rd;
   assign ex_reg_we           = ex_q.we && !ex_q.is_load;
   assign mem_req_reg_we      = mem_req_q.we && !mem_req_q.is_load;
   assign mem_resp_reg_we     = mem_resp_q.we && !mem_resp_q.is_load;
   assign wb_reg_we           = wb_q.we;
   assign mem_req_alu_result  = mem_req_result;
   assign mem_resp_alu_result = mem_resp_result;

endmodule
